// File: rtl/sparrow_lsu.sv
// -----------------------------------------------------------------------------
// sparrow_lsu -- load/store unit sitting directly after the decoder.
//
// Takes the decoded memory controls (request, write enable, access size,
// zero-extend) together with the ALU address and rs2 store data. It runs one
// transaction at a time on a req/gnt/rvalid data bus. It also stalls the
// pipeline until that transaction completes, and returns aligned and extended
// load data for write-back.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   ex_req_i .. ex_wdata_i  memory op from execute; held stable while busy
//   lsu_busy_o              pipeline stall (ex_req_i & ~lsu_done_o)
//   lsu_done_o/err_o        completion pulse and its error flag
//   lsu_rdata_o             extended load result, valid with lsu_done_o
//   data_*                  data bus: registered request side, response in
//
// Handshake: a request is presented with data_req_o=1 and all bus fields are
// held stable until the cycle data_gnt_i=1; that cycle is the transfer.
// Exactly one data_rvalid_i response follows each grant (loads and stores),
// and it is only accepted in WAIT. Anything seen on rvalid in IDLE or REQ is
// dropped.
// -----------------------------------------------------------------------------
module sparrow_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_req_i,
  input  logic                  ex_wr_en_i,
  input  logic [1:0]            ex_size_i,
  input  logic                  ex_zero_extend_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [31:0]           ex_wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Last WAIT count before the forced error completion; the counter is only
  // as wide as that value needs.
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned CW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  state_e                state_q, state_d;
  logic                  data_req_q, data_req_d;
  logic                  data_we_q, data_we_d;
  logic [3:0]            data_be_q, data_be_d;
  logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
  logic [31:0]           data_wdata_q, data_wdata_d;
  logic [1:0]            offset_q, offset_d;
  logic [1:0]            size_q, size_d;
  logic                  zext_q, zext_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  bad_access;
  logic [3:0]            be_new;
  logic [31:0]           wdata_new;
  logic [31:0]           rdata_shifted;
  logic [31:0]           load_data;
  logic                  timeout_hit;

  // Size 2'b10 is illegal; half and word need natural alignment.
  always_comb begin
    bad_access = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = ex_wdata_i;
    case (ex_size_i)
      2'b00: begin
        be_new    = 4'b0001 << ex_addr_i[1:0];
        wdata_new = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        bad_access = ex_addr_i[0];
        be_new     = 4'b0011 << ex_addr_i[1:0];
        wdata_new  = {2{ex_wdata_i[15:0]}};
      end
      2'b11: begin
        bad_access = |ex_addr_i[1:0];
      end
      default: begin
        bad_access = 1'b1;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per access size.
  always_comb begin
    rdata_shifted = data_rdata_i >> {offset_q, 3'b000};
    case (size_q)
      2'b00:   load_data = zext_q ? {24'd0, rdata_shifted[7:0]}
                                  : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = zext_q ? {16'd0, rdata_shifted[15:0]}
                                  : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

  // Completion outputs and next-state logic.
  always_comb begin
    state_d      = state_q;
    data_req_d   = data_req_q;
    data_we_d    = data_we_q;
    data_be_d    = data_be_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    offset_d     = offset_q;
    size_d       = size_q;
    zext_d       = zext_q;
    cnt_d        = '0;
    lsu_done_o   = 1'b0;
    lsu_err_o    = 1'b0;
    lsu_rdata_o  = 32'd0;

    case (state_q)
      IDLE: begin
        if (ex_req_i) begin
          if (bad_access) begin
            // Rejected without touching the bus.
            lsu_done_o = 1'b1;
            lsu_err_o  = 1'b1;
          end else begin
            state_d      = REQ;
            data_req_d   = 1'b1;
            data_we_d    = ex_wr_en_i;
            data_be_d    = be_new;
            data_addr_d  = {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
            data_wdata_d = wdata_new;
            offset_d     = ex_addr_i[1:0];
            size_d       = ex_size_i;
            zext_d       = ex_zero_extend_i;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          state_d    = WAIT;
          data_req_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (data_rvalid_i) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lsu_done_o = 1'b1;
          lsu_err_o  = data_err_i;
          if (!data_we_q && !data_err_i) lsu_rdata_o = load_data;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lsu_done_o = 1'b1;
          lsu_err_o  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        data_req_d = 1'b0;
      end
    endcase
  end

  assign lsu_busy_o = ex_req_i & ~lsu_done_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'd0;
      data_addr_q  <= '0;
      data_wdata_q <= 32'd0;
      offset_q     <= 2'd0;
      size_q       <= 2'd0;
      zext_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      zext_q       <= zext_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_sparrow_lsu.sv
// -----------------------------------------------------------------------------
// tb_sparrow_lsu -- directed bench for sparrow_lsu.
// Inputs change 1 ns after each rising edge; outputs are checked 3 ns after
// the rising edge, well clear of both clock edges.
// -----------------------------------------------------------------------------
module tb_sparrow_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_req, ex_wr_en, ex_zero_extend;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sparrow_lsu #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_req_i(ex_req), .ex_wr_en_i(ex_wr_en), .ex_size_i(ex_size),
    .ex_zero_extend_i(ex_zero_extend), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .lsu_busy_o(lsu_busy), .lsu_done_o(lsu_done), .lsu_err_o(lsu_err),
    .lsu_rdata_o(lsu_rdata),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_we_o(data_we),
    .data_be_o(data_be), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_op(input logic we, input logic [1:0] size, input logic zx,
                          input logic [31:0] addr, input logic [31:0] wdata);
    ex_req         = 1'b1;
    ex_wr_en       = we;
    ex_size        = size;
    ex_zero_extend = zx;
    ex_addr        = addr;
    ex_wdata       = wdata;
  endtask

  // Minimum-latency op: accept, granted request, response on first WAIT cycle.
  task automatic run_min(input string tag, input logic we, input logic [1:0] size,
                         input logic zx, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rsp, input logic rerr,
                         input logic [3:0] e_be, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                         input logic e_err);
    drive_op(we, size, zx, addr, wdata);
    settle();
    chk({tag, "_c0_busy"}, lsu_busy, 1);
    chk({tag, "_c0_done"}, lsu_done, 0);
    chk({tag, "_c0_req"}, data_req, 0);
    next_cycle();
    data_gnt = 1'b1;
    settle();
    chk({tag, "_c1_req"}, data_req, 1);
    chk({tag, "_c1_we"}, data_we, we);
    chk({tag, "_c1_be"}, data_be, e_be);
    chk({tag, "_c1_addr"}, data_addr, e_addr);
    chk({tag, "_c1_wdata"}, data_wdata, e_wdata);
    chk({tag, "_c1_busy"}, lsu_busy, 1);
    chk({tag, "_c1_done"}, lsu_done, 0);
    next_cycle();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = rsp;
    data_err    = rerr;
    settle();
    chk({tag, "_c2_req"}, data_req, 0);
    chk({tag, "_c2_done"}, lsu_done, 1);
    chk({tag, "_c2_err"}, lsu_err, e_err);
    chk({tag, "_c2_rdata"}, lsu_rdata, e_rdata);
    chk({tag, "_c2_busy"}, lsu_busy, 0);
    next_cycle();
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = 32'd0;
    ex_req      = 1'b0;
    settle();
    chk({tag, "_c3_done"}, lsu_done, 0);
    chk({tag, "_c3_req"}, data_req, 0);
  endtask

  initial begin
    rst = 1'b1; ex_req = 1'b0; ex_wr_en = 1'b0; ex_size = 2'b00; ex_zero_extend = 1'b0;
    ex_addr = 32'd0; ex_wdata = 32'd0; data_gnt = 1'b0; data_rvalid = 1'b0;
    data_rdata = 32'd0; data_err = 1'b0;

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("rst_req", data_req, 0);
    chk("rst_we", data_we, 0);
    chk("rst_be", data_be, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_busy", lsu_busy, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_rdata", lsu_rdata, 0);
    next_cycle();

    // ---------------- loads at minimum latency ----------------
    run_min("lb", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 1'b0,
            4'b1000, 32'h0000_1000, 32'd0, 32'hFFFF_FF80, 1'b0);
    run_min("lhu", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 32'h9ABC_1234, 1'b0,
            4'b1100, 32'h0000_2000, 32'd0, 32'h0000_9ABC, 1'b0);
    run_min("lh", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 32'h9ABC_1234, 1'b0,
            4'b1100, 32'h0000_2000, 32'd0, 32'hFFFF_9ABC, 1'b0);
    run_min("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'd0, 32'h1122_F344, 1'b0,
            4'b0010, 32'h0000_1000, 32'd0, 32'h0000_00F3, 1'b0);
    run_min("lw", 1'b0, 2'b11, 1'b0, 32'h0000_1004, 32'd0, 32'h8765_4321, 1'b0,
            4'b1111, 32'h0000_1004, 32'd0, 32'h8765_4321, 1'b0);

    // ---------------- SB with delayed grant ----------------
    drive_op(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56EF);
    settle();
    chk("sb_c0_busy", lsu_busy, 1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      data_gnt = (i == 3);
      settle();
      chk("sb_req", data_req, 1);
      chk("sb_we", data_we, 1);
      chk("sb_be", data_be, 4'b0010);
      chk("sb_addr", data_addr, 32'h0000_3000);
      chk("sb_wdata", data_wdata, 32'hEFEF_EFEF);
      chk("sb_busy", lsu_busy, 1);
      next_cycle();
    end
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'hFFFF_FFFF;
    settle();
    chk("sb_done", lsu_done, 1);
    chk("sb_err", lsu_err, 0);
    chk("sb_rdata", lsu_rdata, 0);
    chk("sb_busy_end", lsu_busy, 0);
    chk("sb_req_end", data_req, 0);
    next_cycle();
    data_rvalid = 1'b0; data_rdata = 32'd0; ex_req = 1'b0;

    // ---------------- misaligned / illegal size ----------------
    drive_op(1'b0, 2'b11, 1'b0, 32'h0000_4002, 32'd0);
    settle();
    chk("mis_lw_done", lsu_done, 1);
    chk("mis_lw_err", lsu_err, 1);
    chk("mis_lw_busy", lsu_busy, 0);
    chk("mis_lw_rdata", lsu_rdata, 0);
    next_cycle();
    chk("mis_lw_req", data_req, 0);
    drive_op(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0);
    settle();
    chk("ill_sz_done", lsu_done, 1);
    chk("ill_sz_err", lsu_err, 1);
    chk("ill_sz_busy", lsu_busy, 0);
    next_cycle();
    chk("ill_sz_req", data_req, 0);
    ex_req = 1'b0;
    next_cycle();
    chk("mis_req_after", data_req, 0);

    // ---------------- timeout ----------------
    drive_op(1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'd0);
    next_cycle();
    data_gnt = 1'b1;
    settle();
    chk("to_req", data_req, 1);
    next_cycle();
    data_gnt = 1'b0;
    for (int w = 1; w <= 15; w++) begin
      settle();
      chk("to_wait_done", lsu_done, 0);
      chk("to_wait_busy", lsu_busy, 1);
      next_cycle();
    end
    settle();
    chk("to_done", lsu_done, 1);
    chk("to_err", lsu_err, 1);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_busy", lsu_busy, 0);
    next_cycle();
    ex_req = 1'b0;
    settle();
    chk("to_idle_req", data_req, 0);
    chk("to_idle_done", lsu_done, 0);
    next_cycle();

    // ---------------- error response ----------------
    run_min("rerr", 1'b0, 2'b11, 1'b0, 32'h0000_5004, 32'd0, 32'hDEAD_BEEF, 1'b1,
            4'b1111, 32'h0000_5004, 32'd0, 32'd0, 1'b1);

    // ---------------- reset in WAIT, stale rvalid ----------------
    drive_op(1'b0, 2'b11, 1'b0, 32'h0000_7000, 32'd0);
    next_cycle();
    data_gnt = 1'b1;
    next_cycle();
    data_gnt = 1'b0;
    settle();
    chk("rw_wait_busy", lsu_busy, 1);
    chk("rw_wait_done", lsu_done, 0);
    rst    = 1'b1;
    ex_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rw_req", data_req, 0);
    chk("rw_be", data_be, 0);
    chk("rw_done", lsu_done, 0);
    next_cycle();
    data_rvalid = 1'b1;
    data_rdata  = 32'h1234_5678;
    settle();
    chk("rw_stale_done", lsu_done, 0);
    chk("rw_stale_err", lsu_err, 0);
    chk("rw_stale_rdata", lsu_rdata, 0);
    chk("rw_stale_req", data_req, 0);
    next_cycle();
    data_rvalid = 1'b0;
    data_rdata  = 32'd0;

    run_min("sw", 1'b1, 2'b11, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 32'd0, 1'b0,
            4'b1111, 32'h0000_6000, 32'hCAFE_F00D, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall guard so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
